// File: rtl/stepping_rotor.sv
// stepping_rotor: one programmable stepping rotor stage with position, ring, notch and turnover carry.
// Define STEPPING_ROTOR_OUTREG_EN to register OUT/OUTINV (one cycle of latency).
module stepping_rotor #(
  parameter int N = 26,
  parameter int PW = $clog2(N),
  parameter int NOTCH_RST = N - 1
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic [N-1:0]  D,
  input  logic [N-1:0]  DINV,
  output logic [N-1:0]  OUT,
  output logic [N-1:0]  OUTINV,
  input  logic          STEP,
  input  logic          LOAD,
  input  logic [PW-1:0] LOAD_POS,
  input  logic [PW-1:0] LOAD_RING,
  input  logic [PW-1:0] LOAD_NOTCH,
  input  logic          WR_EN,
  input  logic [PW-1:0] WR_ADDR,
  input  logic [PW-1:0] WR_DATA,
  output logic [PW-1:0] POS,
  output logic          AT_NOTCH,
  output logic          CARRY
);
  localparam logic [PW:0] NN = (PW+1)'(N);

  function automatic logic [PW-1:0] add_mod(input logic [PW-1:0] a, input logic [PW-1:0] b);
    logic [PW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= NN) ? PW'(s - NN) : PW'(s);
  endfunction

  function automatic logic [PW-1:0] sub_mod(input logic [PW-1:0] a, input logic [PW-1:0] b);
    return (a >= b) ? a - b : PW'({1'b0, a} + NN - {1'b0, b});
  endfunction

  function automatic logic [PW-1:0] red(input logic [PW-1:0] a);
    return ({1'b0, a} >= NN) ? PW'({1'b0, a} - NN) : a;
  endfunction

  logic [PW-1:0] ring, notch, k;
  logic [PW-1:0] fwd_tab [N];
  logic [PW-1:0] inv_tab [N];
  logic [N-1:0]  fwd, bwd;
  logic          wr_ok;

  assign AT_NOTCH = (POS == notch);
  assign k = sub_mod(POS, ring);
  assign wr_ok = WR_EN && ({1'b0, WR_ADDR} < NN) && ({1'b0, WR_DATA} < NN);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      POS <= '0;
      ring <= '0;
      notch <= PW'(NOTCH_RST);
      CARRY <= 1'b0;
    end else begin
      POS <= LOAD ? red(LOAD_POS) : STEP ? add_mod(POS, PW'(1)) : POS;
      ring <= LOAD ? red(LOAD_RING) : ring;
      notch <= LOAD ? red(LOAD_NOTCH) : notch;
      CARRY <= STEP && !LOAD && AT_NOTCH;
    end
  end

  // Inverse table is kept in step with the forward table so the return path needs no search.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < N; i++) begin
        fwd_tab[i] <= PW'(i);
        inv_tab[i] <= PW'(i);
      end
    end else if (wr_ok) begin
      fwd_tab[WR_ADDR] <= WR_DATA;
      inv_tab[WR_DATA] <= WR_ADDR;
    end
  end

  always_comb begin
    fwd = '0;
    bwd = '0;
    for (int i = 0; i < N; i++) begin
      if (D[i]) fwd[sub_mod(fwd_tab[add_mod(PW'(i), k)], k)] = 1'b1;
      if (DINV[i]) bwd[sub_mod(inv_tab[add_mod(PW'(i), k)], k)] = 1'b1;
    end
  end

`ifdef STEPPING_ROTOR_OUTREG_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      OUT <= '0;
      OUTINV <= '0;
    end else begin
      OUT <= fwd;
      OUTINV <= bwd;
    end
  end
`else
  assign OUT = fwd;
  assign OUTINV = bwd;
`endif
endmodule

// File: tb/tb_stepping_rotor.sv
// tb_stepping_rotor: directed scoreboard bench for stepping_rotor (default N=26).
module tb_stepping_rotor;
  localparam int N = 26;
  localparam int PW = 5;
`ifdef STEPPING_ROTOR_OUTREG_EN
  localparam bit REG = 1'b1;
`else
  localparam bit REG = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic [N-1:0]  D = '0, DINV = '0, OUT, OUTINV;
  logic          STEP = 1'b0, LOAD = 1'b0, WR_EN = 1'b0;
  logic [PW-1:0] LOAD_POS = '0, LOAD_RING = '0, LOAD_NOTCH = '0, WR_ADDR = '0, WR_DATA = '0;
  logic [PW-1:0] POS;
  logic          AT_NOTCH, CARRY;

  stepping_rotor dut (
    .CLK(CLK), .RST_N(RST_N), .D(D), .DINV(DINV), .OUT(OUT), .OUTINV(OUTINV),
    .STEP(STEP), .LOAD(LOAD), .LOAD_POS(LOAD_POS), .LOAD_RING(LOAD_RING),
    .LOAD_NOTCH(LOAD_NOTCH), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
    .POS(POS), .AT_NOTCH(AT_NOTCH), .CARRY(CARRY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } item_t;

  item_t q[$];
  int    passed = 0;
  int    total = 0;
  event  chk_now;

  function automatic logic [31:0] sel(input int kind);
    case (kind)
      0: return 32'(OUT);
      1: return 32'(OUTINV);
      2: return 32'(POS);
      3: return 32'(AT_NOTCH);
      default: return 32'(CARRY);
    endcase
  endfunction

  initial begin
    item_t it;
    logic [31:0] act;
    forever begin
      @(negedge CLK or chk_now);
      while (q.size() > 0) begin
        it = q.pop_front();
        act = sel(it.kind);
        total++;
        if (act === it.exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", it.name, act, it.exp);
      end
    end
  end

  task automatic push(input int kind, input logic [31:0] exp, input string name);
    item_t it;
    it.kind = kind;
    it.exp = exp;
    it.name = name;
    q.push_back(it);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    STEP = 1'b0;
    LOAD = 1'b0;
    WR_EN = 1'b0;
  endtask

  task automatic wait_check();
    @(negedge CLK);
    #1;
  endtask

  task automatic do_load(input int p, input int r, input int n, input bit st);
    LOAD = 1'b1;
    LOAD_POS = PW'(p);
    LOAD_RING = PW'(r);
    LOAD_NOTCH = PW'(n);
    STEP = st;
    tick();
  endtask

  task automatic chk_path(input logic [N-1:0] d, input logic [N-1:0] di,
                          input logic [N-1:0] eo, input logic [N-1:0] eoi, input string nm);
    D = d;
    DINV = di;
    if (REG) begin
      @(posedge CLK);
      #1;
    end
    push(0, 32'(eo), {nm, "_out"});
    push(1, 32'(eoi), {nm, "_inv"});
    wait_check();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    string wiring = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
    #12 RST_N = 1'b1;
    push(2, 0, "rst_pos");
    push(4, 0, "rst_carry");
    push(3, 0, "rst_at_notch");
    chk_path(N'(1) << 3, N'(1) << 3, N'(1) << 3, N'(1) << 3, "rst_identity");

    STEP = 1'b1;
    tick();
    push(2, 1, "step_pos");
    wait_check();
    chk_path(N'(1) << 3, '0, N'(1) << 3, '0, "step_identity");

    for (int i = 0; i < N; i++) begin
      WR_EN = 1'b1;
      WR_ADDR = PW'(i);
      WR_DATA = PW'(wiring[i] - 8'd65);
      tick();
    end
    WR_EN = 1'b1; WR_ADDR = 5'd27; WR_DATA = 5'd0; tick();
    WR_EN = 1'b1; WR_ADDR = 5'd3; WR_DATA = 5'd30; tick();

    do_load(0, 0, 25, 1'b0);
    chk_path(N'(1) << 0, N'(1) << 4, N'(1) << 4, N'(1) << 0, "wire_k0");
    chk_path((N'(1) << 0) | (N'(1) << 1), N'(1) << 0, (N'(1) << 4) | (N'(1) << 10), N'(1) << 20, "multi_hot");
    chk_path(N'(1) << 3, '0, N'(1) << 5, '0, "bad_write_ignored");

    do_load(1, 0, 25, 1'b0);
    push(2, 1, "load_pos1");
    chk_path(N'(1) << 0, N'(1) << 9, N'(1) << 9, N'(1) << 0, "pos1_ring0");
    do_load(1, 1, 25, 1'b0);
    chk_path(N'(1) << 0, '0, N'(1) << 4, '0, "pos1_ring1");
    do_load(0, 1, 25, 1'b0);
    chk_path(N'(1) << 0, '0, N'(1) << 10, '0, "ring_wrap");
    do_load(27, 0, 25, 1'b0);
    push(2, 1, "load_reduced");
    wait_check();

    do_load(15, 0, 16, 1'b0);
    push(2, 15, "notch_pos15");
    push(3, 0, "notch_at15");
    wait_check();
    STEP = 1'b1; tick();
    push(2, 16, "notch_pos16");
    push(3, 1, "notch_at16");
    push(4, 0, "notch_carry_early");
    wait_check();
    STEP = 1'b1; tick();
    push(2, 17, "notch_pos17");
    push(3, 0, "notch_at17");
    push(4, 1, "notch_carry");
    wait_check();
    tick();
    push(4, 0, "carry_one_cycle");
    wait_check();

    do_load(25, 0, 16, 1'b0);
    STEP = 1'b1; tick();
    push(2, 0, "wrap_pos");
    push(4, 0, "wrap_carry");
    wait_check();
    do_load(16, 0, 16, 1'b0);
    push(3, 1, "pre_prio_at");
    wait_check();
    do_load(5, 0, 16, 1'b1);
    push(2, 5, "prio_pos");
    push(4, 0, "prio_carry");
    wait_check();

    do_load(16, 0, 16, 1'b0);
    D = N'(1) << 0;
    DINV = N'(1) << 4;
    wait_check();
    STEP = 1'b1; tick();
    push(4, 1, "pre_rst_carry");
    ->chk_now;
    #1;
    RST_N = 1'b0;
    #1;
    push(4, 0, "async_carry");
    push(2, 0, "async_pos");
    push(3, 0, "async_at_notch");
    push(0, REG ? 32'd0 : 32'd1, "async_out");
    push(1, REG ? 32'd0 : 32'(N'(1) << 4), "async_inv");
    ->chk_now;
    #1;
    wait_check();
    RST_N = 1'b1;
    chk_path(N'(1) << 0, N'(1) << 4, N'(1) << 0, N'(1) << 4, "post_rst_identity");

    if (REG) begin
      tick();
      D = N'(1) << 7;
      push(0, 32'd1, "outreg_lag");
      wait_check();
      @(posedge CLK);
      #1;
      push(0, 32'(N'(1) << 7), "outreg_after");
      wait_check();
    end

    repeat (2) wait_check();
    if (q.size() != 0) begin
      total++;
      $display("FAIL drain: %0d unchecked, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/stepping_rotor.md
Name: stepping_rotor

Overview:
- Parametrised, clocked successor of the fixed-wiring rotor stage.
- Holds its own rotor position, ring setting, notch and a run-time programmable wiring table.
- Routes the forward and inverse one-hot paths through the current rotor offset.
- Issues turnover (carry) to the next rotor, so a chain of these stages forms a complete stepping rotor bank between plugboard and reflector.

Parameters:
- N, 26, alphabet size; width of every one-hot bus.
- PW, $clog2(N), width of position/ring/notch/address fields.
- NOTCH_RST, N-1, notch position after reset.

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- D  input  N  forward one-hot contact input.
- DINV  input  N  inverse (return) one-hot contact input.
- OUT  output  N  forward one-hot output.
- OUTINV  output  N  inverse one-hot output.
- STEP  input  1  advance position by one this cycle.
- LOAD  input  1  load LOAD_POS/LOAD_RING/LOAD_NOTCH.
- LOAD_POS  input  PW  new position.
- LOAD_RING  input  PW  new ring setting.
- LOAD_NOTCH  input  PW  new notch position.
- WR_EN  input  1  wiring table write strobe.
- WR_ADDR  input  PW  wiring entry contact.
- WR_DATA  input  PW  wiring exit contact.
- POS  output  PW  current position register.
- AT_NOTCH  output  1  POS == notch, combinational from registers.
- CARRY  output  1  registered one-cycle turnover pulse to next rotor.

Behaviour:
- Reset (RST_N low, asynchronous):
  - POS=0, ring=0, notch=NOTCH_RST, CARRY=0.
  - Wiring and inverse tables reset to identity: WIRE[i]=i, INV[i]=i.
- Registers update only on rising CLK while RST_N is high.
- Offset k = (POS - ring) mod N. All arithmetic is mod N in PW+1 bits: add, then subtract N if the result is >= N; subtraction adds N if negative.
- Forward path (combinational, zero latency): for each hot bit i of D, OUT bit (WIRE[(i+k) mod N] - k) mod N is set.
- Inverse path: same mapping with INV in place of WIRE, applied from DINV to OUTINV.
- Multi-hot input maps bitwise; output popcount equals input popcount. All-zero input gives all-zero output.
- STEP: POS <= (POS+1) mod N, wrapping N-1 -> 0.
  - If STEP and AT_NOTCH in the same cycle, CARRY=1 on the next cycle for exactly one cycle; otherwise CARRY=0.
  - Double-stepping is external: the bank controller ORs AT_NOTCH of the middle rotor into its own STEP.
- LOAD: POS, ring and notch load on the next edge.
  - LOAD has priority over STEP: the simultaneous STEP is dropped and no CARRY is produced.
  - LOAD values >= N are reduced mod N (subtract N once).
- WR_EN: WIRE[WR_ADDR] <= WR_DATA and INV[WR_DATA] <= WR_ADDR on the next edge.
  - The new mapping is visible on OUT/OUTINV from the following cycle.
  - WR_ADDR or WR_DATA >= N: write ignored.
  - Software must write a full permutation before use. A non-permutation gives undefined inverse results but no lockup.
- WR_EN, LOAD and STEP are independent apart from the LOAD/STEP priority, and may coincide in one cycle.
- Reset mid-operation: all state returns to reset values immediately; CARRY drops asynchronously.

Optional Feature:
- Macro STEPPING_ROTOR_OUTREG_EN.
- Defined:
  - OUT and OUTINV are registered, giving one cycle of latency, reset to 0.
  - The registered path uses the POS/table values present at the sampling edge.
- Undefined: OUT and OUTINV are purely combinational, with zero latency.

Test Plan:
- Identity after reset, N=26, D=1<<3 -> OUT=1<<3.
  - STEP once, D=1<<3 -> OUT=1<<3, since identity is offset-invariant.
- Program wiring EKMFLGDQVZNTOWYHXUSPAIBRCJ (26 writes), POS=0, ring=0:
  - D=1<<0 -> OUT=1<<4.
  - DINV=1<<4 -> OUTINV=1<<0.
- Same wiring, LOAD POS=1, ring=0:
  - D=1<<0 -> entry 1 -> K(10) -> 10-1=9 -> OUT=1<<9.
  - LOAD POS=1, ring=1 -> OUT=1<<4.
- Notch=16, POS=15:
  - STEP, STEP -> POS=17.
  - CARRY high exactly the cycle after the second STEP.
  - AT_NOTCH high only while POS=16.
- POS=25, STEP -> POS=0.
  - LOAD POS=5 with STEP in the same cycle -> POS=5, CARRY=0.
- Assert RST_N low mid-sequence after programming -> tables revert to identity, POS=0, CARRY=0 without a clock edge.
  - With STEPPING_ROTOR_OUTREG_EN defined, OUT lags D by exactly one cycle.
